// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/freeze control with a drained interrupt entry sequence.
module pipeline_hazard_ctrl (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRt,
  input  logic       ID_Jump,
  input  logic       EX_MemRead,
  input  logic [4:0] EX_Rt,
  input  logic       EX_BranchTaken,
  input  logic       mem_busy,
  input  logic       irq_req,
  input  logic       irq_mask,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       IF_Flush,
  output logic       ID_EX_Bubble,
  output logic       pipe_hold,
  output logic       PC_Sel_Irq,
  output logic       irq_ack,
  output logic [7:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, IRQ_DRAIN, IRQ_ENTER} state_t;
  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       load_use;
  assign load_use = EX_MemRead & (EX_Rt != 5'd0) &
                    ((EX_Rt == ID_Rs) | (ID_UsesRt & (EX_Rt == ID_Rt)));
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_Flush     = 1'b0;
    ID_EX_Bubble = 1'b0;
    pipe_hold    = 1'b0;
    PC_Sel_Irq   = 1'b0;
    if (mem_busy) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      pipe_hold   = 1'b1;
    end else begin
      case (state)
        IRQ_DRAIN: begin
          PC_Write     = 1'b0;
          IF_Flush     = 1'b1;
          ID_EX_Bubble = 1'b1;
          cnt_nxt      = cnt - 2'd1;
          state_nxt    = (cnt == 2'd1) ? IRQ_ENTER : IRQ_DRAIN;
        end
        IRQ_ENTER: begin
          PC_Sel_Irq = 1'b1;
          IF_Flush   = 1'b1;
          state_nxt  = RUN;
        end
        default: begin
          state_nxt = RUN;
          // RUN priority: branch > irq > jump > load-use
          if (EX_BranchTaken) begin
            IF_Flush     = 1'b1;
            ID_EX_Bubble = 1'b1;
          end else if (irq_req && !irq_mask) begin
            PC_Write     = 1'b0;
            IF_Flush     = 1'b1;
            ID_EX_Bubble = 1'b1;
            state_nxt    = IRQ_DRAIN;
            cnt_nxt      = 2'd2;
          end else if (ID_Jump) begin
            IF_Flush = 1'b1;
          end else if (load_use) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
          end
        end
      endcase
    end
  end
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      cnt       <= 2'd0;
      irq_ack   <= 1'b0;
      stall_cnt <= 8'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      irq_ack <= (state == IRQ_ENTER) && !mem_busy;
      if (!PC_Write && stall_cnt != 8'hff) stall_cnt <= stall_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random checks against a cycle-phase reference model.
module tb_pipeline_hazard_ctrl;
  logic       sysclk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] ID_Rs = '0, ID_Rt = '0, EX_Rt = '0;
  logic       ID_UsesRt = 1'b0, ID_Jump = 1'b0, EX_MemRead = 1'b0, EX_BranchTaken = 1'b0;
  logic       mem_busy = 1'b0, irq_req = 1'b0, irq_mask = 1'b0;
  logic       PC_Write, IF_ID_Write, IF_Flush, ID_EX_Bubble, pipe_hold, PC_Sel_Irq, irq_ack;
  logic [7:0] stall_cnt;
  int n_cmp = 0, n_err = 0;
  // model: phase 0 = running, 1/2 = drain cycles, 3 = vector entry
  int         m_phase = 0;
  int         m_cnt = 0;
  logic       m_ack = 1'b0;
  logic [5:0] m_out;
  always #5 sysclk = ~sysclk;
  pipeline_hazard_ctrl dut (
    .sysclk(sysclk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_Jump(ID_Jump), .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .EX_BranchTaken(EX_BranchTaken),
    .mem_busy(mem_busy), .irq_req(irq_req), .irq_mask(irq_mask), .PC_Write(PC_Write),
    .IF_ID_Write(IF_ID_Write), .IF_Flush(IF_Flush), .ID_EX_Bubble(ID_EX_Bubble),
    .pipe_hold(pipe_hold), .PC_Sel_Irq(PC_Sel_Irq), .irq_ack(irq_ack), .stall_cnt(stall_cnt)
  );
  // {PC_Write, IF_ID_Write, IF_Flush, ID_EX_Bubble, pipe_hold, PC_Sel_Irq}
  function automatic logic [5:0] expect_out();
    bit lu;
    lu = EX_MemRead && EX_Rt != 0 && (EX_Rt == ID_Rs || (ID_UsesRt && EX_Rt == ID_Rt));
    if (mem_busy) return 6'b000010;
    if (m_phase == 1 || m_phase == 2) return 6'b011100;
    if (m_phase == 3) return 6'b111001;
    if (EX_BranchTaken) return 6'b111100;
    if (irq_req && !irq_mask) return 6'b011100;
    if (ID_Jump) return 6'b111000;
    if (lu) return 6'b000100;
    return 6'b110000;
  endfunction
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask
  task automatic check_all(input string tag);
    m_out = expect_out();
    chk({tag, ".ctrl"}, int'({PC_Write, IF_ID_Write, IF_Flush, ID_EX_Bubble, pipe_hold, PC_Sel_Irq}), int'(m_out));
    chk({tag, ".ack"}, int'(irq_ack), int'(m_ack));
    chk({tag, ".cnt"}, int'(stall_cnt), m_cnt);
  endtask
  task automatic step(input string tag, input bit busy, input bit br, input bit irq, input bit msk,
                      input bit jmp, input bit mr, input logic [4:0] ert, input logic [4:0] rs,
                      input logic [4:0] rt, input bit ur);
    mem_busy = busy; EX_BranchTaken = br; irq_req = irq; irq_mask = msk; ID_Jump = jmp;
    EX_MemRead = mr; EX_Rt = ert; ID_Rs = rs; ID_Rt = rt; ID_UsesRt = ur;
    #1;
    check_all(tag);
    @(posedge sysclk);
    if (!m_out[5] && m_cnt < 255) m_cnt++;
    m_ack = (m_phase == 3) && !busy;
    if (!busy) m_phase = (m_phase == 0) ? ((!br && irq && !msk) ? 1 : 0) : (m_phase + 1) % 4;
    @(negedge sysclk);
  endtask
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    m_phase = 0; m_cnt = 0; m_ack = 1'b0;
    check_all(tag);
    @(posedge sysclk);
    @(negedge sysclk);
    check_all({tag, ".held"});
    reset = 1'b1;
  endtask
  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask
  initial begin
    @(negedge sysclk);
    do_reset("reset");
    idle("normal");
    step("load_use", 0, 0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd3, 0);
    chk("load_use.cnt1", int'(stall_cnt), 1);
    step("load_use_rt", 0, 0, 0, 0, 0, 1, 5'd9, 5'd1, 5'd9, 1);
    step("rt_unused", 0, 0, 0, 0, 0, 1, 5'd9, 5'd1, 5'd9, 0);
    step("zero_rt", 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);
    step("jump", 0, 0, 0, 0, 1, 1, 5'd4, 5'd4, 5'd0, 0);
    step("masked_irq", 0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step("br_vs_irq", 0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step("irq_take", 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step("drain1", 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    step("drain2", 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step("enter", 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    chk("irq.ack_pulse", int'(irq_ack), 1);
    idle("after_ack");
    chk("irq.ack_drop", int'(irq_ack), 0);
    do_reset("reset2");
    step("irq2", 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step("drain_a", 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    for (int i = 0; i < 4; i++) step("drain_busy", 1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step("drain_b", 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step("enter_busy", 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step("enter2", 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    chk("irq2.ack", int'(irq_ack), 1);
    step("irq3", 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step("drain3a", 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step("drain3b", 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    do_reset("reset_in_enter");
    for (int i = 0; i < 3; i++) idle("post_abort");
    for (int i = 0; i < 300; i++) step("sat", 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    chk("sat.cnt255", int'(stall_cnt), 255);
    idle("sat_hold");
    do_reset("reset3");
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset("reset_rand");
      step("rand", $urandom_range(5) == 0, $urandom_range(7) == 0, $urandom_range(4) == 0,
           $urandom_range(2) == 0, $urandom_range(6) == 0, $urandom_range(1) == 1,
           5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)), $urandom_range(1) == 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
